// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;
    localparam int XLen         = 32;
    localparam int MemAddrWidth = 10;
    localparam int BeWidth      = XLen / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction, legality.
module lsu_align
    import lsu_pkg::*;
(
    input  logic               we,
    input  logic [2:0]         funct3,
    input  logic [1:0]         offset,
    input  logic [XLen-1:0]    wdata,
    input  logic [XLen-1:0]    rdata_raw,
    output logic [BeWidth-1:0] be,
    output logic [XLen-1:0]    wdata_rep,
    output logic [XLen-1:0]    load_val,
    output logic               fault
);
    logic [XLen-1:0] lane;

    // Addressed byte/halfword moved down to bit 0.
    assign lane = rdata_raw >> {offset, 3'b000};

    // Width decode; rejected accesses never enable any byte lane.
    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        load_val  = lane;
        fault     = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                load_val  = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
                fault     = we & funct3[2];
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
                load_val  = funct3[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                fault     = offset[0] | (we & funct3[2]);
            end
            F3_W: begin
                be    = 4'b1111;
                fault = |offset;
            end
            default: fault = 1'b1;
        endcase
        if (fault) be = '0;
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one core access at a time onto a req/gnt/rvalid word memory.
module lsu
    import lsu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [2:0]              funct3_i,
    input  logic [XLen-1:0]         addr_i,
    input  logic [XLen-1:0]         wdata_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    fault_o,
    output logic [XLen-1:0]         rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [BeWidth-1:0]      mem_be_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [XLen-1:0]         mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [XLen-1:0]         mem_rdata_i
);
    state_e state, state_n;

    logic       we_q, fault_q;
    logic [2:0] f3_q;
    logic [1:0] off_q;

    logic               a_we;
    logic [2:0]         a_f3;
    logic [1:0]         a_off;
    logic [BeWidth-1:0] be;
    logic [XLen-1:0]    wdata_rep, load_val;
    logic               fault;
    logic               accept;

    // Idle decodes the live request; afterwards the captured fields drive the lanes.
    assign a_we   = (state == IDLE) ? we_i         : we_q;
    assign a_f3   = (state == IDLE) ? funct3_i     : f3_q;
    assign a_off  = (state == IDLE) ? addr_i[1:0]  : off_q;
    assign accept = (state == IDLE) && req_i;

    lsu_align u_align (
        .we        (a_we),
        .funct3    (a_f3),
        .offset    (a_off),
        .wdata     (wdata_i),
        .rdata_raw (mem_rdata_i),
        .be        (be),
        .wdata_rep (wdata_rep),
        .load_val  (load_val),
        .fault     (fault)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_n   = state;
        ready_o   = 1'b0;
        done_o    = 1'b0;
        fault_o   = 1'b0;
        mem_req_o = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (req_i) state_n = fault ? DONE : ISSUE;
            end
            ISSUE: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_n = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) state_n = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                fault_o = fault_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture the request and memory-side fields once; they stay put through the handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            fault_q     <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
        end else begin
            if (accept) begin
                we_q        <= we_i;
                f3_q        <= funct3_i;
                off_q       <= addr_i[1:0];
                fault_q     <= fault;
                mem_we_o    <= we_i & ~fault;
                mem_be_o    <= be;
                mem_addr_o  <= addr_i[MemAddrWidth+1:2];
                mem_wdata_o <= wdata_rep;
            end
            if ((state == WAIT) && mem_rvalid_i) rdata_o <= load_val;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a transaction-level reference model and per-cycle compare.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        ready_o, done_o, fault_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    lsu dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o),
        .fault_o(fault_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    bit          chk_en = 0;
    logic        exp_ready = 1, exp_req = 0, exp_done = 0, exp_fault = 0, exp_we = 0;
    logic [3:0]  exp_be = '0;
    logic [9:0]  exp_addr = '0;
    logic [31:0] exp_wdata = '0, exp_rdata = '0;
    bit          exp_be_chk = 0;
    logic [31:0] got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: legality, lane enables, replication, extraction.
    function automatic bit model_fault(input bit we, input logic [2:0] f3, input logic [1:0] off);
        bit legal;
        int sz;
        sz    = int'(f3[1:0]);
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((int'(off) % (1 << sz)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        int n;
        n = 1 << f3[1:0];
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        int n;
        logic [31:0] v, mask;
        n = 1 << f3[1:0];
        v = w >> (8 * off);
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 1;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic idle_exp();
        exp_ready  = 1; exp_req = 0; exp_done = 0; exp_fault = 0; exp_be_chk = 0;
    endtask

    // Per-cycle comparison against the model's expected view.
    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("ready_o", ready_o, exp_ready);
            chk("done_o", done_o, exp_done);
            chk("fault_o", fault_o, exp_fault);
            chk("mem_req_o", mem_req_o, exp_req);
            chk("rdata_o", rdata_o, exp_rdata);
            if (exp_req) begin
                chk("mem_be_o", mem_be_o, exp_be);
                chk("mem_addr_o", mem_addr_o, exp_addr);
                chk("mem_wdata_o", mem_wdata_o, exp_wdata);
                chk("mem_we_o", mem_we_o, exp_we);
            end
            if (exp_be_chk) chk("fault_be", mem_be_o, 4'b0000);
        end
    end

    // One complete access; gd = cycles of grant delay, rv = rvalid cycles after grant.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int gd, input int rv, input logic [31:0] word,
                          input bit lit_en, input logic [9:0] lit_addr, input logic [3:0] lit_be,
                          input logic [31:0] lit_wdata, output logic [31:0] res);
        bit f;
        f = model_fault(we, f3, a[1:0]);
        @(posedge clk_i); #1;
        req_i = 1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = d; idle_exp();
        @(posedge clk_i); #1;
        req_i = 0; exp_ready = 0;
        if (f) begin
            exp_done = 1; exp_fault = 1; exp_be_chk = 1;
        end else begin
            exp_req = 1; exp_be = model_be(f3, a[1:0]); exp_addr = a[11:2];
            exp_wdata = model_wdata(f3, d); exp_we = we;
            if (lit_en) begin
                chk("lit_addr", mem_addr_o, lit_addr);
                chk("lit_be", mem_be_o, lit_be);
                chk("lit_wdata", mem_wdata_o, lit_wdata);
            end
            for (int c = 0; c <= gd; c++) begin
                mem_gnt_i = (c == gd);
                @(posedge clk_i); #1;
            end
            mem_gnt_i = 0; exp_req = 0;
            if (!we) begin
                mem_rdata_i = word;
                for (int c = 1; c <= rv; c++) begin
                    mem_rvalid_i = (c == rv);
                    @(posedge clk_i); #1;
                end
                mem_rvalid_i = 0;
                exp_rdata = model_load(f3, a[1:0], word);
            end
            exp_done = 1;
        end
        res = rdata_o;
        @(posedge clk_i); #1;
        idle_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_fault", fault_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_be", mem_be_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_rdata", rdata_o, 0);
        idle_exp(); exp_rdata = 0; chk_en = 1;
        @(posedge clk_i); #1; rst_i = 0;

        // Stores: immediate grant, then a delayed grant holding outputs stable
        access(1, F3_W, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1, 10'd4, 4'b1111, 32'hDEADBEEF, got);
        access(1, F3_B, 32'h13, 32'h000000A5, 3, 0, 0, 1, 10'd4, 4'b1000, 32'hA5A5A5A5, got);
        access(1, F3_H, 32'h2A, 32'h1234BEEF, 1, 0, 0, 1, 10'd10, 4'b1100, 32'hBEEFBEEF, got);

        // Loads of one word through every width and sign option
        access(0, F3_B,  32'h103, 0, 0, 2, 32'h80FF7F01, 0, 0, 0, 0, got);
        chk("LB@3", got, 32'hFFFFFF80);
        access(0, F3_BU, 32'h103, 0, 1, 2, 32'h80FF7F01, 0, 0, 0, 0, got);
        chk("LBU@3", got, 32'h00000080);
        access(0, F3_H,  32'h102, 0, 0, 2, 32'h80FF7F01, 0, 0, 0, 0, got);
        chk("LH@2", got, 32'hFFFF80FF);
        access(0, F3_HU, 32'h100, 0, 2, 2, 32'h80FF7F01, 0, 0, 0, 0, got);
        chk("LHU@0", got, 32'h00007F01);
        access(0, F3_B,  32'h101, 0, 0, 1, 32'h80FF7F01, 0, 0, 0, 0, got);
        chk("LB@1", got, 32'h0000007F);
        access(0, F3_W,  32'h104, 0, 0, 1, 32'h80FF7F01, 0, 0, 0, 0, got);
        chk("LW@0", got, 32'h80FF7F01);

        // Rejected accesses leave memory and rdata_o untouched
        access(0, F3_W,   32'h22, 0, 0, 1, 0, 0, 0, 0, 0, got);
        chk("fault_rdata_hold", got, 32'h80FF7F01);
        access(1, F3_H,   32'h01, 32'h5555, 0, 1, 0, 0, 0, 0, 0, got);
        access(0, 3'b011, 32'h00, 0, 0, 1, 0, 0, 0, 0, 0, got);
        access(1, F3_BU,  32'h00, 32'h11, 0, 1, 0, 0, 0, 0, 0, got);

        // Reset while requesting: request drops without waiting for a clock
        @(posedge clk_i); #1;
        req_i = 1; we_i = 1; funct3_i = F3_W; addr_i = 32'h40; wdata_i = 32'h01020304; idle_exp();
        @(posedge clk_i); #1;
        req_i = 0; exp_ready = 0; exp_req = 1; exp_be = 4'b1111; exp_addr = 10'h10;
        exp_wdata = 32'h01020304; exp_we = 1;
        #1; rst_i = 1; #1;
        chk("rst_issue_req", mem_req_o, 0);
        chk("rst_issue_ready", ready_o, 1);
        idle_exp(); exp_rdata = 0;
        @(posedge clk_i); #1; rst_i = 0;

        // Reset while waiting for load data, then a stray rvalid in idle
        access(0, F3_W, 32'h44, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, got);
        @(posedge clk_i); #1;
        req_i = 1; we_i = 0; funct3_i = F3_W; addr_i = 32'h48; idle_exp();
        @(posedge clk_i); #1;
        req_i = 0; exp_ready = 0; exp_req = 1; exp_be = 4'b1111; exp_addr = 10'h12;
        exp_wdata = wdata_i; exp_we = 0; mem_gnt_i = 1;
        @(posedge clk_i); #1;
        mem_gnt_i = 0; exp_req = 0;
        #1; rst_i = 1; #1;
        chk("rst_wait_req", mem_req_o, 0);
        chk("rst_wait_ready", ready_o, 1);
        idle_exp(); exp_rdata = 0;
        @(posedge clk_i); #1; rst_i = 0;
        mem_rdata_i = 32'h12345678; mem_rvalid_i = 1;
        @(posedge clk_i); #1; mem_rvalid_i = 0;
        @(posedge clk_i); #1;
        chk("stray_rvalid_rdata", rdata_o, 32'h0);
        access(1, F3_W, 32'h50, 32'h0BADC0DE, 0, 0, 0, 1, 10'h14, 4'b1111, 32'h0BADC0DE, got);

        @(posedge clk_i); #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the rv32i multicycle datapath and the word-organised data RAM. Accepts one load or store request at a time from the core and issues a word-aligned, byte-enabled request/grant/rvalid transaction to memory. Returns sign- or zero-extended load data, and flags misaligned or illegal accesses without touching memory.

## Interface
- XLen, 32: data and byte-address width.
- MemAddrWidth, 10: memory word-address width, matching the 1024-word RAM.

- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  core request; sampled only when ready_o=1.
- we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  RV32I width/sign field (LB/LH/LW/LBU/LHU, SB/SH/SW).
- addr_i  in  XLen  byte address.
- wdata_i  in  XLen  store data, right-aligned.
- ready_o  out  1  unit idle, can accept req_i.
- done_o  out  1  one-cycle completion pulse.
- fault_o  out  1  high together with done_o when the access was rejected.
- rdata_o  out  XLen  extended load result; valid from done_o, held until next completion.
- mem_req_o  out  1  memory request, held until mem_gnt_i.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  MemAddrWidth  word address = addr[MemAddrWidth+1:2].
- mem_wdata_o  out  XLen  lane-replicated store data.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  load data valid, never before the cycle after mem_gnt_i.
- mem_rdata_i  in  XLen  raw word read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: ready_o=1. On req_i, capture we/funct3/addr/wdata.
  - Legal access: go to ISSUE.
  - Illegal or misaligned access: go to DONE with fault latched.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - All other codes are faults.
- Misalignment:
  - Halfword with addr[0]=1 is a fault.
  - Word with addr[1:0]≠0 is a fault.
- ISSUE: mem_req_o=1, with address/be/we/wdata stable from captured values.
  - On mem_gnt_i, a store goes to DONE.
  - On mem_gnt_i, a load goes to WAIT.
- WAIT: on mem_rvalid_i, register the extended data into rdata_o and go to DONE.
- DONE: done_o=1 and fault_o=captured fault; go to IDLE next cycle.
- Byte enables by width:
  - Byte: mem_be_o = 4'b0001 << addr[1:0], with wdata[7:0] replicated to all four lanes.
  - Half: mem_be_o = 4'b0011 << addr[1:0], with wdata[15:0] replicated twice.
  - Word: mem_be_o = 4'b1111.
- Load extract: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- On a faulted access:
  - No memory request is issued.
  - rdata_o is unchanged.
  - mem_be_o=0.

## Timing
- Reset values:
  - State is IDLE.
  - ready_o=1.
  - done_o, fault_o, mem_req_o, mem_we_o = 0.
  - mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0.
- Reset mid-operation: mem_req_o drops asynchronously and the transaction is abandoned. A late mem_rvalid_i arriving in IDLE is ignored.
- Request accepted in cycle 0:
  - mem_req_o rises in cycle 1.
  - Store with grant in cycle g: done_o in cycle g+1. Minimum latency is 2 cycles.
  - Load with rvalid in cycle v: done_o and the new rdata_o in cycle v+1. Minimum latency is 3 cycles.
  - Fault: done_o=fault_o=1 in cycle 1.
- req_i while not ready_o is ignored, so the core must hold or re-present it.
- A new request is accepted only from the cycle after done_o, giving back-to-back throughput of one access per latency+1 cycles.
- Memory outputs are registered and do not change while mem_req_o=1 and mem_gnt_i=0.

## Structure
- Package lsu_pkg holds:
  - state_e enum (IDLE/ISSUE/WAIT/DONE).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Width of mem_be_o (XLen/8).
- Sub-module lsu_align is purely combinational. From funct3, addr[1:0] and data it produces:
  - The byte enables.
  - The replicated store data.
  - The extracted/extended load value.
  - The fault flag.
- FSM and registers stay in lsu.

## Test plan
- SW 0xDEADBEEF to 0x10, gnt in cycle 1 → mem_addr_o=4, be=1111, wdata=0xDEADBEEF, done_o in cycle 2, fault_o=0.
- SB 0x000000A5 to 0x13, gnt delayed 3 cycles → mem_req_o and outputs held stable, be=1000, wdata=0xA5A5A5A5, done_o the cycle after gnt.
- Load word 0x80FF7F01 via LB/LBU/LH/LHU at offsets 0–3, rvalid 2 cycles after gnt:
  - LB@3 → 0xFFFFFF80.
  - LBU@3 → 0x00000080.
  - LH@2 → 0xFFFF80FF.
  - LHU@0 → 0x00007F01.
- Fault cases → done_o=fault_o=1 in cycle 1 and mem_req_o never asserted:
  - LW at 0x22.
  - SH at 0x01.
  - funct3=011 load.
- Assert rst_i while in WAIT → mem_req_o=0 and ready_o=1 immediately. A subsequent stray mem_rvalid_i produces no done_o; the next SW completes normally.
